// File: rtl/ctrl_fsm_multi_if.sv
// ---------------------------------------------------------------------------
// ctrl_fsm_multi_if
// Instruction-issue handshake between an instruction source and the
// multi-cycle control unit.
//   ir_valid : source -> unit, an instruction is present on ir_data
//   ir_data  : source -> unit, instruction word (INSTR_W bits)
//   ir_ready : unit -> source, the unit can accept an instruction
// Modports: master = instruction source, slave = control unit.
// ---------------------------------------------------------------------------
interface ctrl_fsm_multi_if #(
  parameter int INSTR_W = 16
) ();
  logic               ir_valid;
  logic [INSTR_W-1:0] ir_data;
  logic               ir_ready;

  modport master (output ir_valid, output ir_data, input ir_ready);
  modport slave  (input ir_valid, input ir_data, output ir_ready);
endinterface

// File: rtl/ctrl_fsm_multi.sv
// ---------------------------------------------------------------------------
// ctrl_fsm_multi
// Multi-cycle control unit. Accepts instructions over a valid/ready
// handshake and sequences FETCH -> READ -> EXEC -> WB for ALU ops, a single
// BR cycle for jumps, an ILL cycle for undefined opcodes and a sticky HALT.
// Keeps the program counter and the carry/zero flags latched in EXEC.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   ir_bus (slave)      : ir_valid / ir_data / ir_ready instruction handshake
//   cy, zero            : ALU carry / zero, sampled at the end of EXEC
//   addr1, addr2        : register-file read addresses (rs1, rs2)
//   wr_addr             : register-file write address (rd)
//   rd, wr              : register-file read / write strobes
//   alu_ctrl            : ALU operation select
//   pc                  : program counter
//   flag_cy, flag_z     : latched carry / zero flags
//   halted              : HLT has executed
//   illegal             : one-cycle pulse on an undefined opcode
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module ctrl_fsm_multi #(
  parameter int INSTR_W = 16,
  parameter int RADDR_W = 3,
  parameter int PC_W    = 8,
  parameter int ALU_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  ctrl_fsm_multi_if.slave    ir_bus,
  input  logic               cy,
  input  logic               zero,
  output logic [RADDR_W-1:0] addr1,
  output logic [RADDR_W-1:0] addr2,
  output logic [RADDR_W-1:0] wr_addr,
  output logic               rd,
  output logic               wr,
  output logic [ALU_W-1:0]   alu_ctrl,
  output logic [PC_W-1:0]    pc,
  output logic               flag_cy,
  output logic               flag_z,
  output logic               halted,
  output logic               illegal
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_MOV = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b1000;
  localparam logic [3:0] OP_JZ  = 4'b1001;
  localparam logic [3:0] OP_JC  = 4'b1010;
  localparam logic [3:0] OP_HLT = 4'b1100;

  // Field positions, counted down from the MSB.
  localparam int RD_HI  = INSTR_W - 5;
  localparam int RS1_HI = RD_HI - RADDR_W;
  localparam int RS2_HI = RS1_HI - RADDR_W;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_BR    = 3'd4,
    S_ILL   = 3'd5,
    S_HALT  = 3'd6
  } state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: is_alu_op = 1'b1;
      default:                                       is_alu_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_br_op(input logic [3:0] op);
    case (op)
      OP_JMP, OP_JZ, OP_JC: is_br_op = 1'b1;
      default:              is_br_op = 1'b0;
    endcase
  endfunction

  function automatic logic [ALU_W-1:0] alu_sel(input logic [3:0] op);
    case (op)
      OP_ADD:  alu_sel = ALU_W'(0);
      OP_SUB:  alu_sel = ALU_W'(1);
      OP_AND:  alu_sel = ALU_W'(2);
      OP_OR:   alu_sel = ALU_W'(3);
      OP_XOR:  alu_sel = ALU_W'(4);
      OP_MOV:  alu_sel = ALU_W'(5);
      default: alu_sel = ALU_W'(0);
    endcase
  endfunction

  state_t               state_r;
  state_t               state_s;

  // Instruction register: only the fields needed after acceptance.
  logic [3:0]           op_r;
  logic [RADDR_W-1:0]   rdf_r;
  logic [PC_W-1:0]      tgt_r;

  logic [RADDR_W-1:0]   addr1_r;
  logic [RADDR_W-1:0]   addr2_r;
  logic [RADDR_W-1:0]   wr_addr_r;
  logic [ALU_W-1:0]     alu_ctrl_r;
  logic [PC_W-1:0]      pc_r;
  logic                 flag_cy_r;
  logic                 flag_z_r;
  logic                 rd_r;
  logic                 wr_r;
  logic                 ir_ready_r;
  logic                 halted_r;
  logic                 illegal_r;

  logic                 accept_s;
  logic                 br_taken_s;
  logic [3:0]           new_op_s;

  assign new_op_s = ir_bus.ir_data[INSTR_W-1 -: 4];
  // ir_ready_r is only high in FETCH, so it doubles as the state qualifier.
  assign accept_s = ir_bus.ir_valid && ir_ready_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (!accept_s) begin
          state_s = S_FETCH;
        end else if (is_alu_op(new_op_s)) begin
          state_s = S_READ;
        end else if (is_br_op(new_op_s)) begin
          state_s = S_BR;
        end else if (new_op_s == OP_HLT) begin
          state_s = S_HALT;
        end else begin
          state_s = S_ILL;
        end
      end
      S_READ:  state_s = S_EXEC;
      S_EXEC:  state_s = S_WB;
      S_WB:    state_s = S_FETCH;
      S_BR:    state_s = S_FETCH;
      S_ILL:   state_s = S_FETCH;
      S_HALT:  state_s = S_HALT;
      default: state_s = S_FETCH;
    endcase
  end

  // Branch condition uses the flags as they stand in the BR cycle, which
  // already include any update from an immediately preceding EXEC.
  always_comb begin
    br_taken_s = 1'b0;
    case (op_r)
      OP_JMP:  br_taken_s = 1'b1;
      OP_JZ:   br_taken_s = flag_z_r;
      OP_JC:   br_taken_s = flag_cy_r;
      default: br_taken_s = 1'b0;
    endcase
  end

  // Datapath registers and strobes; strobes are decoded from the next state
  // so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r       <= 4'b0000;
      rdf_r      <= '0;
      tgt_r      <= '0;
      addr1_r    <= '0;
      addr2_r    <= '0;
      wr_addr_r  <= '0;
      alu_ctrl_r <= '0;
      pc_r       <= '0;
      flag_cy_r  <= 1'b0;
      flag_z_r   <= 1'b0;
      rd_r       <= 1'b0;
      wr_r       <= 1'b0;
      ir_ready_r <= 1'b1;
      halted_r   <= 1'b0;
      illegal_r  <= 1'b0;
    end else begin
      ir_ready_r <= (state_s == S_FETCH);
      rd_r       <= (state_s == S_READ) || (state_s == S_EXEC);
      wr_r       <= (state_s == S_WB);
      illegal_r  <= (state_s == S_ILL);
      halted_r   <= (state_s == S_HALT);

      if (accept_s) begin
        op_r  <= new_op_s;
        rdf_r <= ir_bus.ir_data[RD_HI -: RADDR_W];
        tgt_r <= ir_bus.ir_data[PC_W-1:0];
        pc_r  <= pc_r + PC_W'(1);
        // Read addresses and ALU select only move for ALU ops; otherwise
        // they keep their last values.
        if (is_alu_op(new_op_s)) begin
          addr1_r    <= ir_bus.ir_data[RS1_HI -: RADDR_W];
          addr2_r    <= ir_bus.ir_data[RS2_HI -: RADDR_W];
          alu_ctrl_r <= alu_sel(new_op_s);
        end
      end else if ((state_r == S_BR) && br_taken_s) begin
        pc_r <= tgt_r;
      end

      if (state_r == S_EXEC) begin
        wr_addr_r <= rdf_r;
        // MOV is a pass-through and must not disturb the flags.
        if (op_r != OP_MOV) begin
          flag_cy_r <= cy;
          flag_z_r  <= zero;
        end
      end
    end
  end

  assign ir_bus.ir_ready = ir_ready_r;
  assign addr1           = addr1_r;
  assign addr2           = addr2_r;
  assign wr_addr         = wr_addr_r;
  assign rd              = rd_r;
  assign wr              = wr_r;
  assign alu_ctrl        = alu_ctrl_r;
  assign pc              = pc_r;
  assign flag_cy         = flag_cy_r;
  assign flag_z          = flag_z_r;
  assign halted          = halted_r;
  assign illegal         = illegal_r;

endmodule

// File: tb/tb_ctrl_fsm_multi.sv
// ---------------------------------------------------------------------------
// tb_ctrl_fsm_multi
// Directed self-checking bench for ctrl_fsm_multi with default parameters
// (INSTR_W=16, RADDR_W=3, PC_W=8, ALU_W=3). Expected values are written out
// by hand next to each step.
// ---------------------------------------------------------------------------
module tb_ctrl_fsm_multi;

  logic       clk;
  logic       rst_n;
  logic       cy;
  logic       zero;
  logic [2:0] addr1;
  logic [2:0] addr2;
  logic [2:0] wr_addr;
  logic       rd;
  logic       wr;
  logic [2:0] alu_ctrl;
  logic [7:0] pc;
  logic       flag_cy;
  logic       flag_z;
  logic       halted;
  logic       illegal;

  int n_cmp;
  int n_err;

  ctrl_fsm_multi_if #(.INSTR_W(16)) ir_if ();

  ctrl_fsm_multi #(
    .INSTR_W(16), .RADDR_W(3), .PC_W(8), .ALU_W(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ir_bus   (ir_if.slave),
    .cy       (cy),
    .zero     (zero),
    .addr1    (addr1),
    .addr2    (addr2),
    .wr_addr  (wr_addr),
    .rd       (rd),
    .wr       (wr),
    .alu_ctrl (alu_ctrl),
    .pc       (pc),
    .flag_cy  (flag_cy),
    .flag_z   (flag_z),
    .halted   (halted),
    .illegal  (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past 200000 time units");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for exactly one accepting edge.
  task automatic issue(input logic [15:0] instr);
    ir_if.ir_valid = 1'b1;
    ir_if.ir_data  = instr;
    tick();
    ir_if.ir_valid = 1'b0;
  endtask

  // Run an ALU op through READ/EXEC/WB, driving cy/zero during EXEC.
  task automatic run_alu(input logic [15:0] instr, input logic c, input logic z);
    issue(instr);
    tick();
    cy   = c;
    zero = z;
    tick();
    cy   = 1'b0;
    zero = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    cy    = 1'b0;
    zero  = 1'b0;
    ir_if.ir_valid = 1'b0;
    ir_if.ir_data  = 16'h0000;

    // Reset state.
    #2 rst_n = 1'b0;
    #10;
    check("rst_ready",   32'(ir_if.ir_ready), 32'd1);
    check("rst_pc",      32'(pc),             32'd0);
    check("rst_rd",      32'(rd),             32'd0);
    check("rst_wr",      32'(wr),             32'd0);
    check("rst_halted",  32'(halted),         32'd0);
    check("rst_illegal", 32'(illegal),        32'd0);
    check("rst_flags",   32'({flag_cy, flag_z}), 32'd0);
    #1 rst_n = 1'b1;
    tick();

    // ADD r3 = r1 + r2.
    issue(16'h0650);
    check("add_read_a1",  32'(addr1),    32'd1);
    check("add_read_a2",  32'(addr2),    32'd2);
    check("add_read_alu", 32'(alu_ctrl), 32'd0);
    check("add_read_rd",  32'(rd),       32'd1);
    check("add_read_rdy", 32'(ir_if.ir_ready), 32'd0);
    check("add_pc",       32'(pc),       32'd1);
    tick();
    check("add_exec_rd",  32'(rd),       32'd1);
    check("add_exec_wr",  32'(wr),       32'd0);
    tick();
    check("add_wb_wr",    32'(wr),       32'd1);
    check("add_wb_rd",    32'(rd),       32'd0);
    check("add_wb_waddr", 32'(wr_addr),  32'd3);
    check("add_wb_rdy",   32'(ir_if.ir_ready), 32'd0);
    tick();
    check("add_fetch_wr", 32'(wr),       32'd0);
    check("add_fetch_rdy", 32'(ir_if.ir_ready), 32'd1);

    // SUB r1 = r2 - r3 with cy=1, zero=1, then JZ 0x40 taken.
    issue(16'h1298);
    check("sub_alu", 32'(alu_ctrl), 32'd1);
    tick();
    cy = 1'b1; zero = 1'b1;
    tick();
    cy = 1'b0; zero = 1'b0;
    check("sub_flag_z",  32'(flag_z),  32'd1);
    check("sub_flag_cy", 32'(flag_cy), 32'd1);
    tick();
    issue(16'h9040);
    check("jz_br_rdy", 32'(ir_if.ir_ready), 32'd0);
    check("jz_br_pc",  32'(pc),             32'd3);
    tick();
    check("jz_taken_pc",  32'(pc),             32'h40);
    check("jz_taken_rdy", 32'(ir_if.ir_ready), 32'd1);
    check("jz_flags",     32'({flag_cy, flag_z}), 32'd3);

    // SUB with zero=0, JZ not taken -> pc = 0x40 + 2.
    run_alu(16'h1298, 1'b0, 1'b0);
    check("sub2_flag_z", 32'(flag_z), 32'd0);
    issue(16'h9040);
    tick();
    check("jz_nt_pc", 32'(pc), 32'h42);

    // SUB sets cy=1; MOV with cy=0 keeps flags; JC 0x10 taken.
    run_alu(16'h1298, 1'b1, 1'b0);
    check("sub3_flag_cy", 32'(flag_cy), 32'd1);
    issue(16'h5840);
    check("mov_alu", 32'(alu_ctrl), 32'd5);
    check("mov_a1",  32'(addr1),    32'd1);
    tick();
    cy = 1'b0; zero = 1'b1;
    tick();
    cy = 1'b0; zero = 1'b0;
    check("mov_wb_waddr", 32'(wr_addr), 32'd4);
    check("mov_flag_cy",  32'(flag_cy), 32'd1);
    check("mov_flag_z",   32'(flag_z),  32'd0);
    tick();
    issue(16'hA010);
    check("jc_br_pc", 32'(pc), 32'h45);
    tick();
    check("jc_taken_pc", 32'(pc),    32'h10);
    check("jc_hold_a1",  32'(addr1), 32'd1);

    // Illegal opcode 0111, then ADD runs normally.
    issue(16'h7000);
    check("ill_pulse", 32'(illegal), 32'd1);
    check("ill_rdwr",  32'({rd, wr}), 32'd0);
    check("ill_pc",    32'(pc),      32'h11);
    tick();
    check("ill_clear", 32'(illegal), 32'd0);
    check("ill_rdy",   32'(ir_if.ir_ready), 32'd1);
    issue(16'h0650);
    check("add2_rd",  32'(rd), 32'd1);
    check("add2_pc",  32'(pc), 32'h12);
    tick();
    tick();
    check("add2_wb",  32'({wr, wr_addr}), 32'hB);
    tick();

    // JMP to 0xFF, then an accepted instruction wraps pc to 0.
    issue(16'h80FF);
    tick();
    check("jmp_pc", 32'(pc), 32'hFF);
    issue(16'h7000);
    check("wrap_pc", 32'(pc), 32'h00);
    tick();

    // Reset in the middle of WB.
    issue(16'h0650);
    tick();
    tick();
    check("mid_wb_wr", 32'(wr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr",  32'(wr),             32'd0);
    check("mid_rst_pc",  32'(pc),             32'd0);
    check("mid_rst_rdy", 32'(ir_if.ir_ready), 32'd1);
    #2 rst_n = 1'b1;
    tick();

    // HLT with ir_valid held high.
    ir_if.ir_valid = 1'b1;
    ir_if.ir_data  = 16'hC000;
    tick();
    check("hlt_halted", 32'(halted),          32'd1);
    check("hlt_rdy",    32'(ir_if.ir_ready),  32'd0);
    check("hlt_pc",     32'(pc),              32'd1);
    ir_if.ir_data = 16'h0650;
    repeat (20) tick();
    check("hlt_hold_pc",  32'(pc),             32'd1);
    check("hlt_hold",     32'(halted),         32'd1);
    check("hlt_hold_rdw", 32'({rd, wr, ir_if.ir_ready}), 32'd0);
    ir_if.ir_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("hlt_rst_halted", 32'(halted),         32'd0);
    check("hlt_rst_rdy",    32'(ir_if.ir_ready), 32'd1);
    #2 rst_n = 1'b1;
    tick();
    issue(16'h0650);
    check("post_hlt_rd", 32'(rd), 32'd1);
    check("post_hlt_pc", 32'(pc), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
